// File: rtl/exe_stage_pkg.sv
// Shared constants, opcode/state enums and decode helpers for the execute stage.
package exe_stage_pkg;

    localparam int WIDTH = 32;
    localparam int PC_W  = WIDTH - 2;
    localparam int OP_HI = WIDTH - 1;
    localparam int OP_LO = WIDTH - 6;
    localparam int OP_W  = OP_HI - OP_LO + 1;
    localparam int IMM_W = 16;

    typedef enum logic [OP_W-1:0] {
        OP_NOP = 6'd0,
        OP_ADD = 6'd1,
        OP_SUB = 6'd2,
        OP_AND = 6'd3,
        OP_OR  = 6'd4,
        OP_XOR = 6'd5,
        OP_SLT = 6'd6,
        OP_MUL = 6'd7,
        OP_BEQ = 6'd8
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Unassigned opcode values collapse to NOP so they never produce a result.
    function automatic opcode_e decode_op(input logic [OP_W-1:0] field);
        case (field)
            6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8: return opcode_e'(field);
            default:                                        return OP_NOP;
        endcase
    endfunction

    // PC-relative target: next word plus sign-extended offset, wrapping at PC width.
    function automatic logic [PC_W-1:0] branch_target(input logic [PC_W-1:0] pc,
                                                      input logic [IMM_W-1:0] imm);
        logic [PC_W-1:0] offset;
        logic [PC_W-1:0] one;
        offset = {{(PC_W-IMM_W){imm[IMM_W-1]}}, imm};
        one    = {{(PC_W-1){1'b0}}, 1'b1};
        return pc + one + offset;
    endfunction

endpackage

// File: rtl/exe_stage_if.sv
// ID_EXE -> EXE -> EXE_MEM bundle; master is the surrounding pipeline, slave is the stage.
interface exe_stage_if;
    import exe_stage_pkg::*;

    logic [WIDTH-1:0] IR_in;
    logic [PC_W-1:0]  PC_in;
    logic [WIDTH-1:0] X_in;
    logic [WIDTH-1:0] Y_in;
    logic [WIDTH-1:0] IR_out;
    logic [PC_W-1:0]  PC_out;
    logic [WIDTH-1:0] Z_out;
    logic [WIDTH-1:0] Y_out;
    logic             valid_out;
    logic             stall;
    logic             br_taken;
    logic [PC_W-1:0]  br_target;

    modport master (
        output IR_in, PC_in, X_in, Y_in,
        input  IR_out, PC_out, Z_out, Y_out, valid_out, stall, br_taken, br_target
    );

    modport slave (
        input  IR_in, PC_in, X_in, Y_in,
        output IR_out, PC_out, Z_out, Y_out, valid_out, stall, br_taken, br_target
    );
endinterface

// File: rtl/exe_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, low W bits of a*b.
module exe_mul
    import exe_stage_pkg::*;
#(
    parameter int W     = WIDTH,
    parameter int STEPS = W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] p
);
    localparam int CNT_W = $clog2(STEPS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

    logic [W-1:0]     mcand_reg;
    logic [W-1:0]     mplier_reg;
    logic [W-1:0]     acc_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             busy_reg;

    // Load operands on start, then add-and-shift once per cycle until the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b0;
        end else if (start) begin
            mcand_reg  <= a;
            mplier_reg <= b;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b1;
        end else if (busy_reg) begin
            if (mplier_reg[0]) begin
                acc_reg <= acc_reg + mcand_reg;
            end
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg + 1'b1;
            if (cnt_reg == LAST) begin
                busy_reg <= 1'b0;
            end
        end
    end

    // done flags the cycle whose closing edge performs the final step.
    assign busy = busy_reg;
    assign done = busy_reg && (cnt_reg == LAST);
    assign p    = acc_reg;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: single-cycle ALU/branch ops pass straight through; MUL stalls
// the front end while exe_mul iterates, then presents the result for one cycle.
module exe_stage
    import exe_stage_pkg::*;
#(
    parameter int MUL_CYCLES = WIDTH
) (
    input  logic       clk,
    input  logic       rst,
    exe_stage_if.slave bus
);
    state_e           state_reg;
    state_e           state_next;
    logic [WIDTH-1:0] ir_reg;
    logic [PC_W-1:0]  pc_reg;
    logic [WIDTH-1:0] y_reg;
    logic [WIDTH-1:0] alu_z;
    logic [PC_W-1:0]  target;
    logic [WIDTH-1:0] mul_p;
    logic             mul_busy;
    logic             mul_done;
    logic             mul_start;
    opcode_e          op;
    logic             is_mul;

    assign op        = decode_op(bus.IR_in[OP_HI:OP_LO]);
    assign is_mul    = (op == OP_MUL);
    assign mul_start = (state_reg == ST_IDLE) && is_mul;
    assign target    = branch_target(bus.PC_in, bus.IR_in[IMM_W-1:0]);

    exe_mul #(
        .W     (WIDTH),
        .STEPS (MUL_CYCLES)
    ) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (bus.X_in),
        .b     (bus.Y_in),
        .busy  (mul_busy),
        .done  (mul_done),
        .p     (mul_p)
    );

    // State register; reset overrides any pending transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: IDLE -> BUSY on MUL, BUSY -> DONE on the last step, DONE -> IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (is_mul)   state_next = ST_BUSY;
            ST_BUSY: if (mul_done) state_next = ST_DONE;
            ST_DONE:               state_next = ST_IDLE;
            default:               state_next = ST_IDLE;
        endcase
    end

    // Capture the MUL's IR/PC/store data so DONE can report them unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_reg <= '0;
            pc_reg <= '0;
            y_reg  <= '0;
        end else if (mul_start) begin
            ir_reg <= bus.IR_in;
            pc_reg <= bus.PC_in;
            y_reg  <= bus.Y_in;
        end
    end

    // Single-cycle ALU; MUL and BEQ contribute zero here.
    always_comb begin
        alu_z = '0;
        case (op)
            OP_ADD:  alu_z = bus.X_in + bus.Y_in;
            OP_SUB:  alu_z = bus.X_in - bus.Y_in;
            OP_AND:  alu_z = bus.X_in & bus.Y_in;
            OP_OR:   alu_z = bus.X_in | bus.Y_in;
            OP_XOR:  alu_z = bus.X_in ^ bus.Y_in;
            OP_SLT:  alu_z = {{(WIDTH-1){1'b0}}, ($signed(bus.X_in) < $signed(bus.Y_in))};
            default: alu_z = '0;
        endcase
    end

    // Outputs per state; everything forced quiet while reset is held.
    always_comb begin
        bus.IR_out    = '0;
        bus.PC_out    = '0;
        bus.Z_out     = '0;
        bus.Y_out     = '0;
        bus.valid_out = 1'b0;
        bus.stall     = 1'b0;
        bus.br_taken  = 1'b0;
        bus.br_target = '0;
        if (!rst) begin
            case (state_reg)
                ST_IDLE: begin
                    bus.IR_out    = bus.IR_in;
                    bus.PC_out    = bus.PC_in;
                    bus.Y_out     = bus.Y_in;
                    bus.br_target = target;
                    if (is_mul) begin
                        bus.stall = 1'b1;
                    end else begin
                        bus.Z_out     = alu_z;
                        bus.valid_out = (op != OP_NOP);
                        bus.br_taken  = (op == OP_BEQ) && (bus.X_in == bus.Y_in);
                    end
                end
                ST_BUSY: begin
                    bus.IR_out = ir_reg;
                    bus.PC_out = pc_reg;
                    bus.Y_out  = y_reg;
                    bus.stall  = mul_busy;
                end
                ST_DONE: begin
                    bus.IR_out    = ir_reg;
                    bus.PC_out    = pc_reg;
                    bus.Y_out     = y_reg;
                    bus.Z_out     = mul_p;
                    bus.valid_out = 1'b1;
                end
                default: begin
                    bus.valid_out = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: stimulus queues expected results, a negedge
// monitor pops and compares whenever valid_out is presented.
module tb_exe_stage;

    typedef struct {
        logic [31:0] ir;
        logic [29:0] pc;
        logic [31:0] z;
        logic [31:0] y;
        logic        br;
        logic [29:0] tgt;
        logic        chk_tgt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    exe_stage_if bus();

    exe_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    // Monitor: every presented result must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.valid_out === 1'b1) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_valid: got valid_out=1 IR_out=%h Z_out=%h, required no result", bus.IR_out, bus.Z_out);
            end else begin
                mon_e = sb.pop_front();
                if (bus.IR_out !== mon_e.ir || bus.PC_out !== mon_e.pc || bus.Z_out !== mon_e.z ||
                    bus.Y_out !== mon_e.y || bus.br_taken !== mon_e.br || bus.stall !== 1'b0 ||
                    (mon_e.chk_tgt && bus.br_target !== mon_e.tgt)) begin
                    n_err++;
                    $display("FAIL result ir=%h: got Z=%h IR=%h PC=%h Y=%h br=%b tgt=%h stall=%b, required Z=%h IR=%h PC=%h Y=%h br=%b tgt=%h stall=0",
                             mon_e.ir, bus.Z_out, bus.IR_out, bus.PC_out, bus.Y_out, bus.br_taken, bus.br_target, bus.stall,
                             mon_e.z, mon_e.ir, mon_e.pc, mon_e.y, mon_e.br, mon_e.tgt);
                end else begin
                    $display("ok   ir=%h pc=%h Z=%h br=%b tgt=%h", bus.IR_out, bus.PC_out, bus.Z_out, bus.br_taken, bus.br_target);
                end
            end
        end
    end

    // Apply one instruction, queue its expected result, hold it while stalled
    // and check the stall length.
    task automatic run_op(input logic [5:0] op, input logic [15:0] imm, input logic [29:0] pc,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic exp_valid, input logic [31:0] exp_z, input logic exp_br,
                          input logic chk_tgt, input logic [29:0] exp_tgt, input int exp_stall);
        logic [31:0] ir;
        int stalls;
        ir = {op, 10'd0, imm};
        bus.IR_in = ir;
        bus.PC_in = pc;
        bus.X_in  = x;
        bus.Y_in  = y;
        if (exp_valid) sb.push_back('{ir, pc, exp_z, y, exp_br, exp_tgt, chk_tgt});
        stalls = 0;
        @(negedge clk);
        while (bus.stall === 1'b1 && stalls < 100) begin
            stalls++;
            @(negedge clk);
        end
        n_vec++;
        if (stalls != exp_stall) begin
            n_err++;
            $display("FAIL stall_len ir=%h: got %0d stall cycles, required %0d", ir, stalls, exp_stall);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with a live ADD on the inputs: every output must still read zero.
        bus.IR_in = {6'd1, 26'd0};
        bus.PC_in = 30'h55;
        bus.X_in  = 32'd5;
        bus.Y_in  = 32'd6;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (bus.stall !== 1'b0 || bus.valid_out !== 1'b0 || bus.br_taken !== 1'b0 || bus.Z_out !== 32'd0 ||
            bus.IR_out !== 32'd0 || bus.PC_out !== 30'd0 || bus.Y_out !== 32'd0 || bus.br_target !== 30'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got stall=%b valid=%b br=%b Z=%h IR=%h PC=%h Y=%h tgt=%h, required all zero",
                     bus.stall, bus.valid_out, bus.br_taken, bus.Z_out, bus.IR_out, bus.PC_out, bus.Y_out, bus.br_target);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        //     op     imm       pc          x             y             vld z             br   chk  tgt        stall
        run_op(6'd1, 16'h0000, 30'h00000001, 32'h7FFFFFFF, 32'h00000001, 1, 32'h80000000, 0,   0, 30'h0,       0);
        run_op(6'd2, 16'h0000, 30'h00000002, 32'h00000000, 32'h00000001, 1, 32'hFFFFFFFF, 0,   0, 30'h0,       0);
        run_op(6'd6, 16'h0000, 30'h00000003, 32'hFFFFFFFB, 32'h00000003, 1, 32'h00000001, 0,   0, 30'h0,       0);
        run_op(6'd6, 16'h0000, 30'h00000004, 32'h00000003, 32'hFFFFFFFB, 1, 32'h00000000, 0,   0, 30'h0,       0);
        run_op(6'd3, 16'h0000, 30'h00000005, 32'hF0F000FF, 32'h0FF00F0F, 1, 32'h00F0000F, 0,   0, 30'h0,       0);
        run_op(6'd4, 16'h0000, 30'h00000006, 32'hF0F000FF, 32'h0FF00F0F, 1, 32'hFFF00FFF, 0,   0, 30'h0,       0);
        run_op(6'd5, 16'h0000, 30'h00000007, 32'hF0F000FF, 32'h0FF00F0F, 1, 32'hFF000FF0, 0,   0, 30'h0,       0);
        run_op(6'd0, 16'h0000, 30'h00000008, 32'h00000001, 32'h00000002, 0, 32'h0,        0,   0, 30'h0,       0);
        run_op(6'd63,16'h1234, 30'h00000009, 32'h00000001, 32'h00000002, 0, 32'h0,        0,   0, 30'h0,       0);
        run_op(6'd7, 16'h0000, 30'h00000020, 32'h00000006, 32'h00000007, 1, 32'd42,       0,   0, 30'h0,       33);
        run_op(6'd7, 16'h0000, 30'h00000021, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'h00000001, 0,   0, 30'h0,       33);
        run_op(6'd1, 16'h0000, 30'h00000022, 32'h00000002, 32'h00000003, 1, 32'd5,        0,   0, 30'h0,       0);
        run_op(6'd8, 16'hFFFC, 30'h00000010, 32'h0000ABCD, 32'h0000ABCD, 1, 32'h0,        1,   1, 30'h0000000D, 0);
        run_op(6'd8, 16'hFFFC, 30'h00000010, 32'h0000ABCD, 32'h0000ABCE, 1, 32'h0,        0,   1, 30'h0000000D, 0);
        run_op(6'd8, 16'h0000, 30'h3FFFFFFF, 32'h00000011, 32'h00000011, 1, 32'h0,        1,   1, 30'h00000000, 0);

        // Reset ten cycles into a multiply: no result may ever appear for it.
        bus.IR_in = {6'd7, 26'd0};
        bus.PC_in = 30'h40;
        bus.X_in  = 32'd9;
        bus.Y_in  = 32'd9;
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if (bus.stall !== 1'b0 || bus.valid_out !== 1'b0 || bus.Z_out !== 32'd0) begin
            n_err++;
            $display("FAIL reset_mid_mul: got stall=%b valid=%b Z=%h, required stall=0 valid=0 Z=0", bus.stall, bus.valid_out, bus.Z_out);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_op(6'd1, 16'h0000, 30'h00000041, 32'd10,        32'd20,        1, 32'd30,       0,   0, 30'h0,       0);
        run_op(6'd0, 16'h0000, 30'h00000042, 32'd0,         32'd0,         0, 32'h0,        0,   0, 30'h0,       0);
        run_op(6'd0, 16'h0000, 30'h00000043, 32'd0,         32'd0,         0, 32'h0,        0,   0, 30'h0,       0);

        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d results still outstanding, required 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
Execute stage of MyProc2. It consumes IR/PC/X/Y from the ID_EXE pipeline register and produces the ALU result, store data, branch resolution and a pipeline stall. The stall is for a multi-cycle iterative multiplier. Results are combinational for single-cycle ops and feed the EXE_MEM register.

Parameters:
WIDTH, 32 (`WIDTH from params.v), datapath width; PC width is WIDTH-2 (word address).
MUL_CYCLES, WIDTH, number of iterative multiply steps (one multiplier bit per step).

Ports:
clk  in  1  clock; everything on posedge
rst  in  1  synchronous active-high reset
IR_in  in  WIDTH  instruction from ID_EXE
PC_in  in  WIDTH-2  PC from ID_EXE
X_in  in  WIDTH  operand A
Y_in  in  WIDTH  operand B / store data
IR_out  out  WIDTH  instruction to EXE_MEM
PC_out  out  WIDTH-2  PC to EXE_MEM
Z_out  out  WIDTH  ALU/multiply result
Y_out  out  WIDTH  store data passthrough
valid_out  out  1  Z_out/IR_out represent a completed instruction
stall  out  1  upstream (IF, IF_ID, ID_EXE) must hold while high
br_taken  out  1  branch resolved taken
br_target  out  WIDTH-2  branch target PC

Behaviour:
- Decode: opcode = IR_in[WIDTH-1:WIDTH-6]. Ops: NOP=0, ADD, SUB, AND, OR, XOR, SLT, MUL, BEQ. Any other value is treated as NOP.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH. SLT is signed and gives 1 or 0 zero-extended. MUL gives the low WIDTH bits of X*Y (sign-agnostic).
- BEQ: br_taken = (X_in==Y_in). br_target = PC_in + 1 + sext(IR_in[15:0]), truncated to WIDTH-2 bits (wraps). Z_out=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE, non-MUL op:
  - All outputs are combinational from inputs: IR_out=IR_in, PC_out=PC_in, Y_out=Y_in, stall=0.
  - valid_out=1 unless the op is NOP. br_taken is asserted only for BEQ.
- IDLE, MUL op:
  - stall=1, valid_out=0, br_taken=0.
  - At the clock edge, latch IR, PC, X, Y, clear the accumulator, step counter=0, go to BUSY.
- BUSY:
  - stall=1, valid_out=0. Each cycle: if multiplier LSB is set, acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; counter++.
  - After MUL_CYCLES steps (counter==MUL_CYCLES-1 at the edge), go to DONE.
- DONE:
  - stall=0, valid_out=1, Z_out=acc; IR_out/PC_out/Y_out come from the latched copies.
  - IR_in is ignored (it still holds the MUL). Next state is IDLE.
- MUL timing: stall is high for exactly MUL_CYCLES+1 cycles. The result is visible in the cycle after stall drops. ID_EXE loads the next instruction at the edge ending DONE.
- Upstream contract: IR_in/PC_in/X_in/Y_in are stable while stall=1.
- Reset (rst high at an edge): state→IDLE; counter, accumulator and latches cleared.
  - While rst is high: stall=0, valid_out=0, br_taken=0; Z_out, IR_out, PC_out, Y_out, br_target are all 0.
  - A reset mid-multiply aborts the multiply with no result. The first cycle after reset is IDLE and decodes IR_in afresh.
- Simultaneous: rst wins over any FSM transition. A MUL arriving in the DONE cycle is impossible by contract; a BEQ never stalls.

Decomposition:
- params.v holds WIDTH, the opcode constants (OP_NOP..OP_BEQ), the opcode field bounds and the immediate field width. The block includes it under the INCLUDE_PARAMS guard.
- One sub-module, exe_mul, contains the iterative shift-add multiplier.
  - Ports: clk, rst, start, a, b, busy, done, p.
  - It holds the counter and datapath. exe_stage holds the FSM, IR/PC/Y latches, ALU and branch logic.

Test Plan:
- ADD X=0x7FFFFFFF, Y=0x00000001 -> Z_out=0x80000000, valid_out=1, stall=0 in the same cycle; SUB 0-1 -> 0xFFFFFFFF.
- SLT X=0xFFFFFFFB (-5), Y=3 -> Z_out=1; swap operands -> Z_out=0; NOP (IR=0) -> valid_out=0.
- MUL X=6, Y=7 held stable -> stall=1 for 33 consecutive cycles, valid_out=0 throughout; next cycle Z_out=42, valid_out=1, stall=0; then IDLE.
- MUL 0xFFFFFFFF*0xFFFFFFFF -> Z_out=0x00000001 after 33 stall cycles; MUL immediately followed by ADD 2+3 -> ADD result 5 is valid the cycle after DONE.
- BEQ PC_in=0x10, imm=0xFFFC (-4), X==Y -> br_taken=1, br_target=0x0D; with X!=Y -> br_taken=0. PC_in=0x3FFFFFFF, imm=0 -> br_target wraps to 0.
- rst asserted 10 cycles into a MUL -> stall=0, valid_out=0 on the reset cycle; no MUL result is ever emitted; the following ADD executes normally.
